vga_timing_gen: RTL and testbench



---
 rtl/vga_timing_pkg.sv | 42 ++++
 rtl/vga_timing_gen_if.sv | 26 ++
 rtl/vga_pipe_dly.sv | 33 +++
 rtl/vga_timing_gen.sv | 119 +++++++++++
 tb/tb_vga_timing_gen.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - shared video mode constants, polarity constants and counter-width helper
package vga_timing_pkg;

  localparam bit POL_ACTIVE_HIGH = 1'b1;
  localparam bit POL_ACTIVE_LOW  = 1'b0;

  typedef struct packed {
    int h_active;
    int h_fp;
    int h_sync;
    int h_bp;
    int v_active;
    int v_fp;
    int v_sync;
    int v_bp;
    bit hsync_pol;
    bit vsync_pol;
    int pixel_hz;
  } mode_t;

  // 800x525 total, 25 MHz pixel clock
  localparam mode_t VGA_640x480_60 = '{
    h_active: 640, h_fp: 16, h_sync: 96, h_bp: 48,
    v_active: 480, v_fp: 10, v_sync: 2,  v_bp: 33,
    hsync_pol: POL_ACTIVE_LOW, vsync_pol: POL_ACTIVE_LOW,
    pixel_hz: 25_000_000
  };

  // 1040x666 total, 50 MHz pixel clock
  localparam mode_t SVGA_800x600_72 = '{
    h_active: 800, h_fp: 56, h_sync: 120, h_bp: 64,
    v_active: 600, v_fp: 37, v_sync: 6,   v_bp: 23,
    hsync_pol: POL_ACTIVE_HIGH, vsync_pol: POL_ACTIVE_HIGH,
    pixel_hz: 50_000_000
  };

  // Bits needed for a counter running 0..total-1.
  function automatic int cnt_width(input int total);
    return (total < 2) ? 1 : $clog2(total);
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// rtl/vga_timing_gen_if.sv - raster timing bundle between generator and video consumers
// ce: pixel-clock enable into the generator; remaining signals are generator outputs.
interface vga_timing_gen_if #(
  parameter int HW = 11,
  parameter int VW = 10
);
  logic          ce;
  logic          hsync;
  logic          vsync;
  logic          de;
  logic [HW-1:0] hpos;
  logic [VW-1:0] vpos;
  logic          line_start;
  logic          frame_start;
  logic          vblank;

  modport master (
    input  ce,
    output hsync, vsync, de, hpos, vpos, line_start, frame_start, vblank
  );

  modport slave (
    output ce,
    input  hsync, vsync, de, hpos, vpos, line_start, frame_start, vblank
  );
endinterface

// File: rtl/vga_pipe_dly.sv
// rtl/vga_pipe_dly.sv - ce-gated shift register of DEPTH stages with synchronous reset
// Ports: clk, rst (sync, active-high), ce (advance enable), d (W bits in), q (W bits out).
// DEPTH=0 is a plain wire.
module vga_pipe_dly #(
  parameter int           W       = 8,
  parameter int           DEPTH   = 1,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ce,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  if (DEPTH == 0) begin : g_bypass
    assign q = d;
  end else begin : g_stages
    logic [W-1:0] sr [DEPTH];

    always_ff @(posedge clk) begin
      if (rst) begin
        for (int i = 0; i < DEPTH; i++) sr[i] <= RST_VAL;
      end else if (ce) begin
        sr[0] <= d;
        for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
      end
    end

    assign q = sr[DEPTH-1];
  end

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - parametrised VGA/SVGA raster timing generator with ce and output delay
// Ports: clk, rst (sync, active-high), vif (master: ce in; hsync, vsync, de, hpos, vpos,
// line_start, frame_start, vblank out, all registered).
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE  = 800,
  parameter int H_FP      = 56,
  parameter int H_SYNC    = 120,
  parameter int H_BP      = 64,
  parameter int V_ACTIVE  = 600,
  parameter int V_FP      = 37,
  parameter int V_SYNC    = 6,
  parameter int V_BP      = 23,
  parameter bit HSYNC_POL = 1'b1,
  parameter bit VSYNC_POL = 1'b1,
  parameter int HW        = 11,
  parameter int VW        = 10,
  parameter int PIPE_DLY  = 0
) (
  input logic              clk,
  input logic              rst,
  vga_timing_gen_if.master vif
);

  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_FIRST = H_ACTIVE + H_FP;
  localparam int HS_LAST  = H_ACTIVE + H_FP + H_SYNC - 1;
  localparam int VS_FIRST = V_ACTIVE + V_FP;
  localparam int VS_LAST  = V_ACTIVE + V_FP + V_SYNC - 1;

  // Bundle layout: {hsync, vsync, de, line_start, frame_start, vblank, hpos, vpos}
  localparam int OW = 6 + HW + VW;
  localparam logic [OW-1:0] RST_WORD = {~HSYNC_POL, ~VSYNC_POL, 4'b0000, {HW{1'b0}}, {VW{1'b0}}};

  if (HW < cnt_width(H_TOTAL)) begin : g_err_hw
    $error("vga_timing_gen: HW too narrow for H_TOTAL");
  end
  if (VW < cnt_width(V_TOTAL)) begin : g_err_vw
    $error("vga_timing_gen: VW too narrow for V_TOTAL");
  end
  if (H_FP == 0 || H_SYNC == 0 || H_BP == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0) begin : g_err_zero
    $error("vga_timing_gen: porch and sync widths must be non-zero");
  end
  if (PIPE_DLY < 0 || PIPE_DLY > 15) begin : g_err_dly
    $error("vga_timing_gen: PIPE_DLY must be 0..15");
  end

  logic [HW-1:0] h;
  logic [VW-1:0] v;
  logic          h_last;
  logic          v_last;

  assign h_last = (h == HW'(H_TOTAL - 1));
  assign v_last = (v == VW'(V_TOTAL - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      h <= '0;
      v <= '0;
    end else if (vif.ce) begin
      if (h_last) begin
        h <= '0;
        v <= v_last ? '0 : v + 1'b1;
      end else begin
        h <= h + 1'b1;
      end
    end
  end

  // Decode from the pre-advance counter value so stage 0 is coherent with hpos/vpos.
  logic in_hs, in_vs, in_de, is_ls, is_fs, is_vb;

  always_comb begin
    in_hs = (h >= HW'(HS_FIRST)) && (h <= HW'(HS_LAST));
    in_vs = (v >= VW'(VS_FIRST)) && (v <= VW'(VS_LAST));
    in_de = (h < HW'(H_ACTIVE)) && (v < VW'(V_ACTIVE));
    is_ls = (h == '0);
    is_fs = (h == '0) && (v == '0);
    is_vb = (v >= VW'(V_ACTIVE));
  end

  logic [OW-1:0] s0;

  always_ff @(posedge clk) begin
    if (rst) begin
      s0 <= RST_WORD;
    end else if (vif.ce) begin
      s0 <= {in_hs ? HSYNC_POL : ~HSYNC_POL,
             in_vs ? VSYNC_POL : ~VSYNC_POL,
             in_de, is_ls, is_fs, is_vb, h, v};
    end
  end

  logic [OW-1:0] q;

  vga_pipe_dly #(
    .W      (OW),
    .DEPTH  (PIPE_DLY),
    .RST_VAL(RST_WORD)
  ) u_pipe (
    .clk(clk),
    .rst(rst),
    .ce (vif.ce),
    .d  (s0),
    .q  (q)
  );

  assign vif.hsync       = q[OW-1];
  assign vif.vsync       = q[OW-2];
  assign vif.de          = q[OW-3];
  assign vif.line_start  = q[OW-4];
  assign vif.frame_start = q[OW-5];
  assign vif.vblank      = q[OW-6];
  assign vif.hpos        = q[HW+VW-1:VW];
  assign vif.vpos        = q[VW-1:0];

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - scoreboard bench for vga_timing_gen (SVGA default, VGA delayed, tiny mode)
module tb_vga_timing_gen;
  import vga_timing_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ce  = 1'b0;

  always #5 clk = ~clk;

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic        de;
    logic        ls;
    logic        fs;
    logic        vb;
    logic [10:0] h;
    logic [9:0]  v;
  } out_t;

  typedef struct {
    int   k;
    out_t o;
  } rec_t;

  typedef struct {
    int   dut;
    int   k;
    out_t o;
  } dir_t;

  vga_timing_gen_if #(.HW(11), .VW(10)) if0 ();
  vga_timing_gen_if #(.HW(11), .VW(10)) if1 ();
  vga_timing_gen_if #(.HW(5),  .VW(4))  if2 ();

  assign if0.ce = ce;
  assign if1.ce = ce;
  assign if2.ce = ce;

  vga_timing_gen dut0 (.clk(clk), .rst(rst), .vif(if0));

  vga_timing_gen #(
    .H_ACTIVE(VGA_640x480_60.h_active), .H_FP(VGA_640x480_60.h_fp),
    .H_SYNC(VGA_640x480_60.h_sync),     .H_BP(VGA_640x480_60.h_bp),
    .V_ACTIVE(VGA_640x480_60.v_active), .V_FP(VGA_640x480_60.v_fp),
    .V_SYNC(VGA_640x480_60.v_sync),     .V_BP(VGA_640x480_60.v_bp),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .HW(11), .VW(10), .PIPE_DLY(3)
  ) dut1 (.clk(clk), .rst(rst), .vif(if1));

  vga_timing_gen #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(4),
    .V_ACTIVE(6),  .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b0), .HW(5), .VW(4), .PIPE_DLY(1)
  ) dut2 (.clk(clk), .rst(rst), .vif(if2));

  int checks = 0;
  int errors = 0;

  rec_t q0[$];
  rec_t q1[$];
  rec_t q2[$];
  dir_t dirs[$];

  int k0 = 0;
  int k1 = 0;
  int k2 = 0;

  // Expected outputs after k ce ticks since reset, for a generator with delay dly.
  function automatic out_t model(input int k, input int dly,
                                 input int ha, input int hfp, input int hsw, input int hbp,
                                 input int va, input int vfp, input int vsw, input int vbp,
                                 input bit hp, input bit vp);
    out_t o;
    int p, ht, vt, h, v;
    o    = '0;
    o.hs = ~hp;
    o.vs = ~vp;
    p    = k - 1 - dly;
    if (p < 0) return o;
    ht   = ha + hfp + hsw + hbp;
    vt   = va + vfp + vsw + vbp;
    h    = p % ht;
    v    = (p / ht) % vt;
    o.h  = 11'(h);
    o.v  = 10'(v);
    o.de = (h < ha) && (v < va);
    o.hs = ((h >= ha + hfp) && (h < ha + hfp + hsw)) ? hp : ~hp;
    o.vs = ((v >= va + vfp) && (v < va + vfp + vsw)) ? vp : ~vp;
    o.ls = (h == 0);
    o.fs = (h == 0) && (v == 0);
    o.vb = (v >= va);
    return o;
  endfunction

  function automatic out_t mko(input bit hs, input bit vs, input bit de, input bit ls,
                               input bit fs, input bit vb, input int h, input int v);
    return {hs, vs, de, ls, fs, vb, 11'(h), 10'(v)};
  endfunction

  task automatic step(input logic r, input logic c);
    @(negedge clk);
    rst = r;
    ce  = c;
    @(posedge clk);
    if (r) begin
      k0 = 0; k1 = 0; k2 = 0;
    end else if (c) begin
      k0++; k1++; k2++;
    end
    q0.push_back('{k0, model(k0, 0, 800, 56, 120, 64, 600, 37, 6, 23, 1'b1, 1'b1)});
    q1.push_back('{k1, model(k1, 3, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0)});
    q2.push_back('{k2, model(k2, 1, 16, 2, 3, 4, 6, 1, 2, 1, 1'b1, 1'b0)});
  endtask

  task automatic check(input int d, input rec_t r, input out_t a);
    checks++;
    if (a !== r.o) begin
      errors++;
      $display("FAIL sb_dut%0d k=%0d got=%h want=%h", d, r.k, a, r.o);
    end
    foreach (dirs[i]) begin
      if (dirs[i].dut == d && dirs[i].k == r.k) begin
        checks++;
        if (a !== dirs[i].o) begin
          errors++;
          $display("FAIL dir_dut%0d k=%0d got=%h want=%h", d, r.k, a, dirs[i].o);
        end
      end
    end
  endtask

  always @(negedge clk) begin
    rec_t r;
    out_t a;
    if (q0.size() > 0) begin
      r = q0.pop_front();
      a = {if0.hsync, if0.vsync, if0.de, if0.line_start, if0.frame_start, if0.vblank,
           if0.hpos, if0.vpos};
      check(0, r, a);
    end
    if (q1.size() > 0) begin
      r = q1.pop_front();
      a = {if1.hsync, if1.vsync, if1.de, if1.line_start, if1.frame_start, if1.vblank,
           if1.hpos, if1.vpos};
      check(1, r, a);
    end
    if (q2.size() > 0) begin
      r = q2.pop_front();
      a = {if2.hsync, if2.vsync, if2.de, if2.line_start, if2.frame_start, if2.vblank,
           11'(if2.hpos), 10'(if2.vpos)};
      check(2, r, a);
    end
  end

  initial begin
    // SVGA defaults, no delay: hand-derived points around de, hsync and line wrap
    dirs.push_back('{0, 1,    mko(0, 0, 1, 1, 1, 0, 0,    0)});
    dirs.push_back('{0, 800,  mko(0, 0, 1, 0, 0, 0, 799,  0)});
    dirs.push_back('{0, 801,  mko(0, 0, 0, 0, 0, 0, 800,  0)});
    dirs.push_back('{0, 856,  mko(0, 0, 0, 0, 0, 0, 855,  0)});
    dirs.push_back('{0, 857,  mko(1, 0, 0, 0, 0, 0, 856,  0)});
    dirs.push_back('{0, 976,  mko(1, 0, 0, 0, 0, 0, 975,  0)});
    dirs.push_back('{0, 977,  mko(0, 0, 0, 0, 0, 0, 976,  0)});
    dirs.push_back('{0, 1040, mko(0, 0, 0, 0, 0, 0, 1039, 0)});
    dirs.push_back('{0, 1041, mko(0, 0, 1, 1, 0, 0, 0,    1)});
    // 640x480, active-low syncs, 3 extra stages
    dirs.push_back('{1, 3,    mko(1, 1, 0, 0, 0, 0, 0,    0)});
    dirs.push_back('{1, 4,    mko(1, 1, 1, 1, 1, 0, 0,    0)});
    dirs.push_back('{1, 659,  mko(1, 1, 0, 0, 0, 0, 655,  0)});
    dirs.push_back('{1, 660,  mko(0, 1, 0, 0, 0, 0, 656,  0)});
    dirs.push_back('{1, 755,  mko(0, 1, 0, 0, 0, 0, 751,  0)});
    dirs.push_back('{1, 756,  mko(1, 1, 0, 0, 0, 0, 752,  0)});
    // tiny 25x10 mode, 1 extra stage: vsync/vblank and frame wrap
    dirs.push_back('{2, 20,   mko(1, 1, 0, 0, 0, 0, 18,   0)});
    dirs.push_back('{2, 151,  mko(0, 1, 0, 0, 0, 0, 24,   5)});
    dirs.push_back('{2, 177,  mko(0, 0, 0, 1, 0, 1, 0,    7)});
    dirs.push_back('{2, 227,  mko(0, 1, 0, 1, 0, 1, 0,    9)});
    dirs.push_back('{2, 251,  mko(0, 1, 0, 0, 0, 1, 24,   9)});
    dirs.push_back('{2, 252,  mko(0, 1, 1, 1, 1, 0, 0,    0)});

    // reset, with ce both low and high
    step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    step(1'b1, 1'b0);
    // continuous ce: three SVGA lines, several 640 lines, many tiny frames
    for (int i = 0; i < 3200; i++) step(1'b0, 1'b1);
    // ce every second clk: outputs hold on idle clks
    for (int i = 0; i < 600; i++) step(1'b0, 1'(i % 2));
    // a few idle clks, then mid-frame reset (rst wins over ce)
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0);
    step(1'b1, 1'b1);
    step(1'b1, 1'b0);
    // restart from (0,0)
    for (int i = 0; i < 600; i++) step(1'b0, 1'b1);

    repeat (2) @(negedge clk);
    @(posedge clk);
    checks++;
    if (q0.size() + q1.size() + q2.size() != 0) begin
      errors++;
      $display("FAIL sb_drain got=%0d want=0", q0.size() + q1.size() + q2.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
